// File: rtl/rule_pkg.sv
// rtl/rule_pkg.sv - shared types and widths for the rule beat path
package rule_pkg;

  localparam int RULE_DATA_W  = 256;
  localparam int RULE_EMPTY_W = 5;

  typedef struct packed {
    logic                    sop;
    logic                    eop;
    logic [RULE_EMPTY_W-1:0] empty;
    logic [RULE_DATA_W-1:0]  data;
  } rule_beat_t;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } arb_state_t;

endpackage

// File: rtl/rule_skid_buffer.sv
// rtl/rule_skid_buffer.sv - 2-entry valid/ready register slice for rule beats plus source id
module rule_skid_buffer
  import rule_pkg::*;
#(
  parameter int SRC_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_valid,
  input  rule_beat_t       i_beat,
  input  logic [SRC_W-1:0] i_src,
  output logic             o_ready,
  output logic             o_valid,
  output rule_beat_t       o_beat,
  output logic [SRC_W-1:0] o_src,
  input  logic             i_ready
);

  localparam int W = $bits(rule_beat_t) + SRC_W;

  logic [W-1:0] r_mem [2];
  logic         r_wr_ptr;
  logic         r_rd_ptr;
  logic [1:0]   r_cnt;
  logic         w_push;
  logic         w_pop;

  // Ready depends only on occupancy, so the upstream never sees a path from i_ready.
  assign o_ready = (r_cnt != 2'd2);
  assign o_valid = (r_cnt != 2'd0);
  assign w_push  = i_valid & o_ready;
  assign w_pop   = o_valid & i_ready;
  assign {o_beat, o_src} = r_mem[r_rd_ptr];

  // Storage and pointers; entries clear on reset so every output reads zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_cnt    <= 2'd0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= {i_beat, i_src};
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      r_cnt <= r_cnt + {1'b0, w_push} - {1'b0, w_pop};
    end
  end

endmodule

// File: rtl/rule_stream_arbiter.sv
// rtl/rule_stream_arbiter.sv - packet-atomic round-robin merge of rule streams
module rule_stream_arbiter
  import rule_pkg::*;
#(
  parameter int NUM_IN  = 4,
  parameter int DATA_W  = RULE_DATA_W,
  parameter int EMPTY_W = RULE_EMPTY_W,
  parameter int SRC_W   = $clog2(NUM_IN)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_IN-1:0]         in_rule_valid,
  input  logic [NUM_IN-1:0]         in_rule_sop,
  input  logic [NUM_IN-1:0]         in_rule_eop,
  input  logic [NUM_IN*EMPTY_W-1:0] in_rule_empty,
  input  logic [NUM_IN*DATA_W-1:0]  in_rule_data,
  output logic [NUM_IN-1:0]         in_rule_ready,
  output logic                      out_rule_valid,
  output logic                      out_rule_sop,
  output logic                      out_rule_eop,
  output logic [EMPTY_W-1:0]        out_rule_empty,
  output logic [DATA_W-1:0]         out_rule_data,
  output logic [SRC_W-1:0]          out_rule_src,
  input  logic                      out_rule_ready,
  output logic                      busy,
  output logic                      err_proto
);

  arb_state_t       r_state;
  arb_state_t       w_next;
  logic [SRC_W-1:0] r_grant;
  logic [SRC_W-1:0] r_rr_ptr;
  logic             r_first;
  logic             r_err;
  logic [SRC_W-1:0] w_pick;
  logic             w_accept;
  logic             w_skid_valid;
  logic             w_skid_ready;
  rule_beat_t       w_in_beat;
  rule_beat_t       w_out_beat;

  // First requester strictly after the last winner, wrapping around.
  function automatic logic [SRC_W-1:0] rr_pick(input logic [NUM_IN-1:0] req,
                                               input logic [SRC_W-1:0]  ptr);
    logic [SRC_W-1:0] pick;
    logic             found;
    int               idx;
    pick  = '0;
    found = 1'b0;
    for (int k = 1; k <= NUM_IN; k++) begin
      idx = (int'(ptr) + k) % NUM_IN;
      if (!found && req[idx]) begin
        pick  = SRC_W'(idx);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  assign w_pick          = rr_pick(in_rule_valid, r_rr_ptr);
  assign w_in_beat.sop   = in_rule_sop[r_grant];
  assign w_in_beat.eop   = in_rule_eop[r_grant];
  assign w_in_beat.empty = in_rule_empty[int'(r_grant)*EMPTY_W +: EMPTY_W];
  assign w_in_beat.data  = in_rule_data[int'(r_grant)*DATA_W +: DATA_W];
  assign w_skid_valid    = (r_state == ST_LOCKED) & in_rule_valid[r_grant];

  // Next state and the single granted ready bit.
  always_comb begin
    w_next        = r_state;
    in_rule_ready = '0;
    w_accept      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (|in_rule_valid) w_next = ST_LOCKED;
      end
      ST_LOCKED: begin
        in_rule_ready[r_grant] = w_skid_ready;
        w_accept               = in_rule_valid[r_grant] & w_skid_ready;
        if (w_accept && w_in_beat.eop) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // State, grant latch, fairness pointer and sop-framing check.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_grant  <= '0;
      r_rr_ptr <= SRC_W'(NUM_IN - 1);
      r_first  <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_state <= w_next;
      r_err   <= 1'b0;
      if (r_state == ST_IDLE && |in_rule_valid) begin
        r_grant  <= w_pick;
        r_rr_ptr <= w_pick;
        r_first  <= 1'b1;
      end
      if (w_accept) begin
        r_first <= 1'b0;
        r_err   <= r_first ? ~w_in_beat.sop : w_in_beat.sop;
      end
    end
  end

  rule_skid_buffer #(
    .SRC_W (SRC_W)
  ) u_skid (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_valid (w_skid_valid),
    .i_beat  (w_in_beat),
    .i_src   (r_grant),
    .o_ready (w_skid_ready),
    .o_valid (out_rule_valid),
    .o_beat  (w_out_beat),
    .o_src   (out_rule_src),
    .i_ready (out_rule_ready)
  );

  assign out_rule_sop   = w_out_beat.sop;
  assign out_rule_eop   = w_out_beat.eop;
  assign out_rule_empty = w_out_beat.empty;
  assign out_rule_data  = w_out_beat.data;
  assign busy           = (r_state == ST_LOCKED);
  assign err_proto      = r_err;

endmodule

// File: tb/tb_rule_stream_arbiter.sv
// tb/tb_rule_stream_arbiter.sv - self-checking bench for rule_stream_arbiter
module tb_rule_stream_arbiter;

  localparam int N  = 4;
  localparam int DW = 256;
  localparam int EW = 5;
  localparam int SW = 2;

  typedef struct packed {
    logic          sop;
    logic          eop;
    logic [EW-1:0] empty;
    logic [DW-1:0] data;
  } tb_beat_t;

  typedef struct packed {
    logic [SW-1:0] src;
    tb_beat_t      b;
  } tb_exp_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [N-1:0]      in_v = '0, in_s = '0, in_e = '0;
  logic [N*EW-1:0]   in_emp = '0;
  logic [N*DW-1:0]   in_d = '0;
  logic [N-1:0]      in_r;
  logic              out_v, out_s, out_e, out_r = 1'b0;
  logic [EW-1:0]     out_emp;
  logic [DW-1:0]     out_d;
  logic [SW-1:0]     out_src;
  logic              busy, err;

  int total = 0;
  int bad   = 0;

  tb_beat_t  q[N][$];
  tb_exp_t   exp_q[$];
  logic      held[N];
  logic      nxt_first[N];
  logic      wait_flag[N];
  int        wait_cnt[N];
  logic      in_pkt;
  logic [SW-1:0] in_src;
  logic      pend_err;
  logic      prev_stall;
  tb_exp_t   prev_out;
  logic [N-1:0] acc;
  int        vprob = 100, rprob = 100, rdy_force = -1;
  int        cyc = 0;
  int        err_seen;
  int        sop_srcs[$];
  int        in_acc_cyc[$];
  int        out_acc_cyc[$];

  always #5 clk = ~clk;

  rule_stream_arbiter #(.NUM_IN(N), .DATA_W(DW), .EMPTY_W(EW)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_rule_valid  (in_v),
    .in_rule_sop    (in_s),
    .in_rule_eop    (in_e),
    .in_rule_empty  (in_emp),
    .in_rule_data   (in_d),
    .in_rule_ready  (in_r),
    .out_rule_valid (out_v),
    .out_rule_sop   (out_s),
    .out_rule_eop   (out_e),
    .out_rule_empty (out_emp),
    .out_rule_data  (out_d),
    .out_rule_src   (out_src),
    .out_rule_ready (out_r),
    .busy           (busy),
    .err_proto      (err)
  );

  task automatic check(input string tag, input logic [299:0] obs, input logic [299:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic add_pkt(input int i, input int nb, input logic bad_first, input logic bad_mid);
    tb_beat_t b;
    for (int k = 0; k < nb; k++) begin
      b.sop = (k == 0) ? ~bad_first : (bad_mid && k == 1);
      b.eop = (k == nb - 1);
      b.empty = EW'($urandom_range(31));
      for (int w = 0; w < DW / 32; w++) b.data[w*32 +: 32] = $urandom;
      q[i].push_back(b);
    end
  endtask

  // Reference bookkeeping at the sampling point of one cycle.
  task automatic sample();
    tb_beat_t b;
    tb_exp_t  e;
    tb_exp_t  cur;
    check("ready_onehot0", $onehot0(in_r), 1'b1);
    check("err_proto", err, pend_err);
    cur = {out_src, out_s, out_e, out_emp, out_d};
    if (prev_stall) check("out_stable", {out_v, cur}, {1'b1, prev_out});
    err_seen += int'(err);
    for (int i = 0; i < N; i++)
      if (in_v[i] && nxt_first[i] && !wait_flag[i]) begin
        wait_flag[i] = 1'b1;
        wait_cnt[i]  = 0;
      end
    acc = in_v & in_r;
    pend_err = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (acc[i]) begin
        b = q[i][0];
        if (in_pkt) begin
          check("in_atomic", i, in_src);
          pend_err = b.sop;
        end else begin
          pend_err = ~b.sop;
          in_src = SW'(i);
          in_acc_cyc.push_back(cyc);
          for (int j = 0; j < N; j++)
            if (j != i && wait_flag[j]) wait_cnt[j]++;
          if (wait_flag[i]) check("rr_wait_bound", wait_cnt[i] <= N - 1, 1'b1);
          wait_flag[i] = 1'b0;
        end
        in_pkt = ~b.eop;
        exp_q.push_back({SW'(i), b});
      end
    end
    if (out_v && out_r) begin
      if (exp_q.size() == 0) begin
        check("out_spurious", 1'b1, 1'b0);
      end else begin
        e = exp_q.pop_front();
        check("out_beat", cur, e);
      end
      if (out_s) begin
        sop_srcs.push_back(int'(out_src));
        out_acc_cyc.push_back(cyc);
      end
    end
    prev_stall = out_v && !out_r;
    prev_out   = cur;
  endtask

  task automatic step();
    tb_beat_t b;
    for (int i = 0; i < N; i++) begin
      if (q[i].size() > 0) begin
        b = q[i][0];
        in_v[i] = held[i] ? 1'b1 : ($urandom_range(99) < vprob);
        in_s[i] = b.sop;
        in_e[i] = b.eop;
        in_emp[i*EW +: EW] = b.empty;
        in_d[i*DW +: DW]   = b.data;
      end else begin
        in_v[i] = 1'b0;
      end
    end
    out_r = (rdy_force >= 0) ? (rdy_force != 0) : ($urandom_range(99) < rprob);
    @(negedge clk);
    sample();
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < N; i++) begin
      if (acc[i]) begin
        b = q[i].pop_front();
        nxt_first[i] = b.eop;
        held[i] = 1'b0;
      end else begin
        held[i] = in_v[i];
      end
    end
  endtask

  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    #1;
    check("reset_outputs", {out_v, out_s, out_e, out_emp, out_d, out_src, busy, err, in_r}, '0);
    in_v = '0;
    for (int i = 0; i < N; i++) begin
      q[i].delete();
      held[i] = 1'b0;
      nxt_first[i] = 1'b1;
      wait_flag[i] = 1'b0;
      wait_cnt[i] = 0;
    end
    exp_q.delete();
    sop_srcs.delete();
    in_acc_cyc.delete();
    out_acc_cyc.delete();
    in_pkt = 1'b0;
    pend_err = 1'b0;
    prev_stall = 1'b0;
    err_seen = 0;
    rdy_force = -1;
    vprob = 100;
    rprob = 100;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drain(input int budget);
    int   n;
    logic empty;
    n = 0;
    empty = 1'b0;
    while (!empty && n < budget) begin
      step();
      n++;
      empty = (exp_q.size() == 0);
      for (int i = 0; i < N; i++) if (q[i].size() != 0) empty = 1'b0;
    end
    check("drained", empty, 1'b1);
  endtask

  initial begin
    int exp_rr[5];
    int cyc0;
    exp_rr = '{0, 1, 2, 3, 0};

    // Reset mid-packet, then inputs 0 and 2 compete.
    @(posedge clk);
    #1;
    do_reset();
    add_pkt(1, 4, 1'b0, 1'b0);
    step();
    step();
    step();
    check("busy_locked", busy, 1'b1);
    do_reset();
    add_pkt(0, 2, 1'b0, 1'b0);
    add_pkt(2, 2, 1'b0, 1'b0);
    drain(100);
    check("first_pkt_count", sop_srcs.size(), 2);
    if (sop_srcs.size() == 2) begin
      check("first_grant_src", sop_srcs[0], 0);
      check("second_grant_src", sop_srcs[1], 2);
    end

    // Round robin over four 3-beat packets plus a second one on input 0.
    do_reset();
    for (int i = 0; i < N; i++) add_pkt(i, 3, 1'b0, 1'b0);
    add_pkt(0, 3, 1'b0, 1'b0);
    drain(200);
    check("rr_pkt_count", sop_srcs.size(), 5);
    for (int k = 0; k < sop_srcs.size() && k < 5; k++) check("rr_src_order", sop_srcs[k], exp_rr[k]);

    // Single-beat packets on inputs 1 and 3: latency and one-cycle bubble.
    do_reset();
    add_pkt(1, 1, 1'b0, 1'b0);
    add_pkt(3, 1, 1'b0, 1'b0);
    cyc0 = cyc;
    drain(100);
    check("single_count", sop_srcs.size(), 2);
    check("single_in_count", in_acc_cyc.size(), 2);
    if (sop_srcs.size() == 2 && in_acc_cyc.size() == 2 && out_acc_cyc.size() == 2) begin
      check("single_src_a", sop_srcs[0], 1);
      check("single_src_b", sop_srcs[1], 3);
      check("ready_latency", in_acc_cyc[0] - cyc0, 1);
      check("out_latency", out_acc_cyc[0] - cyc0, 2);
      check("in_bubble", in_acc_cyc[1] - in_acc_cyc[0], 2);
      check("out_spacing", out_acc_cyc[1] - out_acc_cyc[0], 2);
    end

    // Downstream stall of five cycles in the middle of a packet.
    do_reset();
    add_pkt(0, 4, 1'b0, 1'b0);
    add_pkt(2, 3, 1'b0, 1'b0);
    rdy_force = 1;
    step();
    step();
    step();
    rdy_force = 0;
    for (int k = 0; k < 5; k++) step();
    rdy_force = -1;
    drain(100);
    check("bp_no_err", err_seen, 0);
    check("bp_pkt_count", sop_srcs.size(), 2);

    // Framing violations: missing first sop, then an extra sop mid-packet.
    do_reset();
    add_pkt(0, 2, 1'b1, 1'b0);
    add_pkt(0, 3, 1'b0, 1'b1);
    drain(100);
    check("err_pulse_count", err_seen, 2);

    // Random stress with valid gaps and downstream throttling.
    do_reset();
    for (int p = 0; p < 10000; p++) add_pkt($urandom_range(N - 1), $urandom_range(1, 3), 1'b0, 1'b0);
    vprob = 75;
    rprob = 75;
    drain(80000);
    check("stress_pkt_count", sop_srcs.size(), 10000);
    check("stress_no_err", err_seen, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
